lead_count_pipe: RTL and testbench

//  Streaming, pipelined leading/trailing run counter for the decode path.

---
 rtl/lead_count_pipe.sv | 173 +++++++++++++++++
 tb/tb_lead_count_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lead_count_pipe.sv
// -----------------------------------------------------------------------------
// lead_count_pipe
//   Streaming, pipelined run-length counter for the unary-prefix stage of the
//   entropy decoder. For each accepted word it returns how many identical bits
//   form a run at the MSB end (leading modes) or the LSB end (trailing modes).
//   The word is first normalised to a "count leading ones" problem, then a
//   binary halving tree computes the count. The tree levels are spread evenly
//   over STAGES elastic pipeline registers. One word per cycle is sustained.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      input word present
//   in_ready   out  1      block accepts input this cycle
//   in_data    in   W_IN   word to scan
//   in_mode    in   2      00 lead ones, 01 lead zeros, 10 trail ones, 11 trail zeros
//   out_valid  out  1      result present
//   out_ready  in   1      downstream accepts result
//   out_count  out  W_OUT  run length, 0..W_IN
//   out_all    out  1      whole word matched (out_count == W_IN)
//   out_mode   out  2      in_mode carried alongside its word
// -----------------------------------------------------------------------------
module lead_count_pipe #(
   parameter int W_IN   = 32,
   parameter int W_OUT  = $clog2(W_IN) + 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] out_count,
   output logic             out_all,
   output logic [1:0]       out_mode
);

   localparam int L   = $clog2(W_IN);
   localparam int LPS = (L + STAGES - 1) / STAGES;

   // Tree state. Node n of level j covers bits [(n+1)*2^j-1 : n*2^j] of the
   // normalised word; cnt holds the true leading-ones count of that node
   // (including the full-node value 2^j), so the root cnt is the final count.
   typedef struct packed {
      logic [W_IN-1:0]             all;
      logic [W_IN-1:0][W_OUT-1:0]  cnt;
   } tree_t;

   // One halving level: combines node pairs of size 2^j into nodes of size 2^(j+1).
   function automatic tree_t tree_level(input tree_t s, input int j);
      tree_t r;
      r = '0;
      for (int n = 0; n < W_IN / 2; n++) begin
         if (n < (W_IN >> (j + 1))) begin
            r.all[n] = s.all[2*n+1] & s.all[2*n];
            if (!s.all[2*n+1])
               r.cnt[n] = s.cnt[2*n+1];
            else if (s.all[2*n])
               r.cnt[n] = W_OUT'(1) << (j + 1);
            else
               r.cnt[n] = s.cnt[2*n] | (W_OUT'(1) << j);
         end
      end
      return r;
   endfunction

   // Applies levels lo..hi-1; a stage may own zero levels when STAGES does not
   // divide L evenly.
   function automatic tree_t tree_levels(input tree_t s, input int lo, input int hi);
      tree_t r;
      r = s;
      for (int j = 0; j < L; j++) begin
         if (j >= lo && j < hi) r = tree_level(r, j);
      end
      return r;
   endfunction

   logic [W_IN-1:0]   w_rev;
   logic [W_IN-1:0]   w_norm;
   tree_t             w_leaf;
   logic [STAGES-1:0] w_vld;
   logic [STAGES-1:0] w_go;
   tree_t             w_st   [STAGES];
   logic [1:0]        w_mode [STAGES];

   // ---- stage 0 input: normalise to a leading-ones problem ----
   always_comb begin
      w_rev  = '0;
      w_leaf = '0;
      for (int i = 0; i < W_IN; i++) w_rev[i] = in_data[W_IN-1-i];
      w_norm = (in_mode[1] ? w_rev : in_data) ^ {W_IN{in_mode[0]}};
      for (int n = 0; n < W_IN; n++) begin
         w_leaf.all[n] = w_norm[n];
         w_leaf.cnt[n] = W_OUT'(w_norm[n]);
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = (k * LPS < L) ? k * LPS : L;
      localparam int HI = ((k + 1) * LPS < L) ? (k + 1) * LPS : L;

      tree_t      w_src;
      tree_t      w_nxt;
      logic       w_src_vld;
      logic [1:0] w_src_mode;
      logic       w_down_go;
      logic       w_unused_st;
      logic       r_vld;
      tree_t      r_st;
      logic [1:0] r_mode;

      if (k == 0) begin : g_first
         assign w_src      = w_leaf;
         assign w_src_vld  = in_valid;
         assign w_src_mode = in_mode;
      end else begin : g_next
         assign w_src      = w_st[k-1];
         assign w_src_vld  = w_vld[k-1];
         assign w_src_mode = w_mode[k-1];
      end

      // A stage may take new content when empty or when its occupant moves on.
      if (k == STAGES - 1) begin : g_tail
         assign w_down_go = out_ready;
      end else begin : g_body
         assign w_down_go = w_go[k+1];
      end

      assign w_go[k]     = !r_vld | w_down_go;
      assign w_nxt       = tree_levels(w_src, LO, HI);
      assign w_vld[k]    = r_vld;
      assign w_st[k]     = r_st;
      assign w_mode[k]   = r_mode;
      // Nodes above the current level width are constant zero and never read.
      assign w_unused_st = ^r_st;

      // ---- stage k register boundary ----
      always_ff @(posedge clk) begin
         if (!rst_n)       r_vld <= 1'b0;
         else if (w_go[k]) r_vld <= w_src_vld;
      end

      if (k == STAGES - 1) begin : g_out_reg
         // The output register is cleared so the outputs read zero after reset.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_st   <= '0;
               r_mode <= 2'b00;
            end else if (w_go[k] && w_src_vld) begin
               r_st   <= w_nxt;
               r_mode <= w_src_mode;
            end
         end
      end else begin : g_mid_reg
         always_ff @(posedge clk) begin
            if (w_go[k] && w_src_vld) begin
               r_st   <= w_nxt;
               r_mode <= w_src_mode;
            end
         end
      end
   end

   assign in_ready  = w_go[0];
   assign out_valid = w_vld[STAGES-1];
   assign out_count = w_st[STAGES-1].cnt[0];
   assign out_all   = w_st[STAGES-1].all[0];
   assign out_mode  = w_mode[STAGES-1];

endmodule

// File: tb/tb_lead_count_pipe.sv
// -----------------------------------------------------------------------------
// tb_lead_count_pipe
//   Bench for lead_count_pipe with W_IN=8, STAGES=2. Directed table of known
//   words, back-to-back random stream, stall, reset-in-flight and an exhaustive
//   all-modes sweep under random valid/ready, all scored against a run-length
//   reference model.
// -----------------------------------------------------------------------------
module tb_lead_count_pipe;

   localparam int W  = 8;
   localparam int WO = 4;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [1:0]    in_mode = 2'b00;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [WO-1:0] out_count;
   logic          out_all;
   logic [1:0]    out_mode;

   lead_count_pipe #(.W_IN(W), .W_OUT(WO), .STAGES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_all   (out_all),
      .out_mode  (out_mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic [1:0]   mode;
      int           cnt;
      logic         all;
   } vec_t;

   typedef struct {
      int         cnt;
      logic       all;
      logic [1:0] mode;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_out = 0;

   // Length of the run of the selected polarity, walked from the selected end.
   function automatic int ref_count(input logic [W-1:0] d, input logic [1:0] m);
      int   c;
      logic run;
      logic pol;
      c   = 0;
      run = 1'b1;
      pol = !m[0];
      for (int i = 0; i < W; i++) begin
         int b;
         b = m[1] ? i : (W - 1 - i);
         if (run && d[b] == pol) c++;
         else run = 1'b0;
      end
      return c;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs and outputs are stable mid-cycle, so the negedge sees
   // exactly the transfers the next rising edge will perform.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (out_valid === 1'b1 && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_out: got count %0d with no word pending", out_count);
            end else begin
               e = sb.pop_front();
               check("stream_count", int'(out_count), e.cnt);
               check("stream_all",   int'(out_all),   int'(e.all));
               check("stream_mode",  int'(out_mode),  int'(e.mode));
            end
         end
         if (in_valid && in_ready === 1'b1) begin
            e.cnt  = ref_count(in_data, in_mode);
            e.all  = (e.cnt == W);
            e.mode = in_mode;
            sb.push_back(e);
         end
      end
   end

   initial begin : watchdog
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t         tbl [7];
      logic [W-1:0] w [5];
      logic [1:0]   m [5];
      int           base;
      int           idx;
      int           cyc;

      tbl[0] = '{8'b1110_0101, 2'b00, 3, 1'b0};
      tbl[1] = '{8'b0001_1111, 2'b01, 3, 1'b0};
      tbl[2] = '{8'b0000_0111, 2'b10, 3, 1'b0};
      tbl[3] = '{8'b1111_0000, 2'b11, 4, 1'b0};
      tbl[4] = '{8'hFF,        2'b00, 8, 1'b1};
      tbl[5] = '{8'h00,        2'b11, 8, 1'b1};
      tbl[6] = '{8'h7F,        2'b00, 0, 1'b0};

      // Reset state
      repeat (2) tick();
      check("rst_out_valid", int'(out_valid), 0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_out_count", int'(out_count), 0);
      check("rst_out_all",   int'(out_all),   0);
      check("rst_out_mode",  int'(out_mode),  0);

      // Directed table with latency check
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_data  = tbl[i].data;
         in_mode  = tbl[i].mode;
         #1;
         check("tbl_in_ready", int'(in_ready), 1);
         tick();
         in_valid = 1'b0;
         check("tbl_lat1_valid", int'(out_valid), 0);
         tick();
         check("tbl_lat2_valid", int'(out_valid), 1);
         check("tbl_count", int'(out_count), tbl[i].cnt);
         check("tbl_all",   int'(out_all),   int'(tbl[i].all));
         check("tbl_mode",  int'(out_mode),  int'(tbl[i].mode));
         tick();
      end

      // Back-to-back random stream
      base = n_out;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         in_mode  = 2'($urandom);
         #1;
         check("b2b_in_ready", int'(in_ready), 1);
         if (i >= S) check("b2b_out_valid", int'(out_valid), 1);
         tick();
      end
      in_valid = 1'b0;
      repeat (2) tick();
      check("b2b_results", n_out - base, 16);
      check("b2b_drained", int'(out_valid), 0);

      // Stall: out_ready low while input keeps offering words
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w[i] = W'($urandom);
         m[i] = 2'($urandom);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         in_mode  = m[i];
         #1;
         check("stall_in_ready",  int'(in_ready),  (i < S) ? 1 : 0);
         check("stall_out_valid", int'(out_valid), (i >= S) ? 1 : 0);
         if (i >= S) begin
            check("stall_hold_count", int'(out_count), ref_count(w[0], m[0]));
            check("stall_hold_mode",  int'(out_mode),  int'(m[0]));
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      base      = n_out;
      repeat (3) tick();
      check("stall_release_results", n_out - base, 2);
      check("stall_release_empty",   int'(out_valid), 0);

      // Reset with two words in flight
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = W'($urandom);
         in_mode  = 2'($urandom);
         #1;
         check("flight_in_ready", int'(in_ready), 1);
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("flight_rst_out_valid", int'(out_valid), 0);
      check("flight_rst_in_ready",  int'(in_ready),  1);
      check("flight_rst_count",     int'(out_count), 0);
      out_ready = 1'b1;
      base      = n_out;
      repeat (3) tick();
      check("flight_no_stale", n_out - base, 0);
      check("flight_idle",     int'(out_valid), 0);

      // Exhaustive 8-bit sweep across all modes under random flow control
      idx = 0;
      cyc = 0;
      while (idx < 4 * (1 << W) && cyc < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = idx[W-1:0];
         in_mode   = idx[W+1:W];
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) idx++;
         tick();
         cyc++;
      end
      check("sweep_accepted", idx, 4 * (1 << W));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      while (sb.size() > 0 && cyc < 100) begin
         tick();
         cyc++;
      end
      check("sweep_sb_empty", sb.size(), 0);
      check("sweep_idle",     int'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
